// File: rtl/delta_arbiter.sv
// Burst-locked two-requester arbiter feeding one Delta unit through a registered output slot.
// Build option: define DELTA_ARB_RR_EN for round-robin ties; otherwise requester 0 wins every tie.
module delta_arbiter #(
  parameter int WIDTH = 32,
  parameter int BLEN  = 6,
  parameter int CW    = $clog2(BLEN)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AS0,
  output logic             oReady_AS0,
  input  logic [WIDTH-1:0] iData_AS0,
  input  logic             iValid_AS1,
  output logic             oReady_AS1,
  input  logic [WIDTH-1:0] iData_AS1,
  output logic             oValid_BM,
  input  logic             iReady_BM,
  output logic [WIDTH-1:0] oData_BM,
  output logic             oSel_BM,
  output logic             oLast_BM,
  output logic [1:0]       oDbgState,
  output logic [CW-1:0]    oDbgCnt
);

  // Handshake: a beat moves on a rising edge exactly when valid and ready are both
  // high; valid never depends on ready, and a held output beat stays stable until taken.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(BLEN - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             r_last_beat;

  logic             w_free;
  logic             w_sel;
  logic             w_acc;
  logic             w_beat_last;
  logic             w_tie_pick;
  logic             w_pick1;
  logic [WIDTH-1:0] w_acc_data;

`ifdef DELTA_ARB_RR_EN
  logic             r_last;
  assign w_tie_pick = ~r_last;
`else
  assign w_tie_pick = 1'b0;
`endif

  always_comb begin
    w_free      = !r_valid || iReady_BM;
    w_sel       = (r_state == ST_GRANT1);
    w_acc_data  = w_sel ? iData_AS1 : iData_AS0;
    w_beat_last = (r_cnt == LAST_CNT);
    w_acc       = 1'b0;
    if (r_state == ST_GRANT0) w_acc = iValid_AS0 && w_free;
    if (r_state == ST_GRANT1) w_acc = iValid_AS1 && w_free;
    // Requester 1 wins when it is alone or when the tie rule points at it.
    w_pick1     = iValid_AS1 && (!iValid_AS0 || w_tie_pick);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_sel       <= 1'b0;
      r_last_beat <= 1'b0;
`ifdef DELTA_ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      if (w_acc) begin
        r_valid     <= 1'b1;
        r_data      <= w_acc_data;
        r_sel       <= w_sel;
        r_last_beat <= w_beat_last;
      end else if (iReady_BM) begin
        r_valid     <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (iValid_AS0 || iValid_AS1)
            r_state <= w_pick1 ? ST_GRANT1 : ST_GRANT0;
        end
        ST_GRANT0, ST_GRANT1: begin
          // The grant is held until the BLEN-th beat, even across requester gaps.
          if (w_acc) begin
            if (w_beat_last) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
`ifdef DELTA_ARB_RR_EN
              r_last  <= w_sel;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign oReady_AS0 = w_free && (r_state == ST_GRANT0);
  assign oReady_AS1 = w_free && (r_state == ST_GRANT1);
  assign oValid_BM  = r_valid;
  assign oData_BM   = r_data;
  assign oSel_BM    = r_sel;
  assign oLast_BM   = r_last_beat;
  assign oDbgState  = r_state;
  assign oDbgCnt    = r_cnt;

endmodule
